// File: rtl/hamming_rx_sequencer_if.sv
// Codeword, decoder and byte-output channels of the Hamming(12,8) receive sequencer.
// slave = sequencer side, master = SPI stage / decoder / downstream side.
interface hamming_rx_sequencer_if;
    logic        cw_valid;
    logic [11:0] cw_data;
    logic        cw_ready;
    logic [11:0] dec_data;
    logic        dec_fram;
    logic        dec_en;
    logic        dec_qvld;
    logic [7:0]  dec_byte;
    logic        dec_err_only;
    logic        dec_err_mul;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_err;
    logic        out_ready;

    modport slave (
        input  cw_valid, cw_data, dec_qvld, dec_byte,
        input  dec_err_only, dec_err_mul, out_ready,
        output cw_ready, dec_data, dec_fram, dec_en,
        output out_valid, out_data, out_err
    );

    modport master (
        output cw_valid, cw_data, dec_qvld, dec_byte,
        output dec_err_only, dec_err_mul, out_ready,
        input  cw_ready, dec_data, dec_fram, dec_en,
        input  out_valid, out_data, out_err
    );
endinterface

// File: rtl/hamming_rx_sequencer.sv
// Hamming(12,8) receive sequencer: codeword -> decoder -> byte, with error counters.
// DROP_MULTI_ERR_EN: uncorrectable codewords are counted but not forwarded.
module hamming_rx_sequencer #(
    parameter int TIMEOUT_CYC = 15,
    parameter int CNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   cnt_clr,
    hamming_rx_sequencer_if.slave  bus,
    output logic [CNT_W-1:0]       corr_cnt,
    output logic [CNT_W-1:0]       uncorr_cnt,
    output logic                   timeout_err,
    output logic                   busy
);
    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT,
        OUT
    } state_t;

    state_t           state_q;
    logic [11:0]      dec_data_q;
    logic             dec_fram_q;
    logic [TW-1:0]    wcnt_q;
    logic             out_valid_q;
    logic [7:0]       out_data_q;
    logic [1:0]       out_err_q;
    logic             timeout_q;
    logic [CNT_W-1:0] corr_q, corr_d;
    logic [CNT_W-1:0] uncorr_q, uncorr_d;
    logic             cap;

    assign cap = (state_q == WAIT) && bus.dec_qvld;

    // Clear has priority over a same-cycle increment.
    always_comb begin
        corr_d   = corr_q;
        uncorr_d = uncorr_q;
        if (cnt_clr) begin
            corr_d   = '0;
            uncorr_d = '0;
        end else if (cap) begin
            if (bus.dec_err_mul) begin
                if (uncorr_q != '1) uncorr_d = uncorr_q + 1'b1;
            end else if (bus.dec_err_only) begin
                if (corr_q != '1) corr_d = corr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dec_data_q  <= '0;
            dec_fram_q  <= 1'b0;
            wcnt_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= '0;
            timeout_q   <= 1'b0;
            corr_q      <= '0;
            uncorr_q    <= '0;
        end else begin
            dec_fram_q <= 1'b0;
            timeout_q  <= 1'b0;
            corr_q     <= corr_d;
            uncorr_q   <= uncorr_d;
            unique case (state_q)
                IDLE: begin
                    if (bus.cw_valid && enable) begin
                        dec_data_q <= bus.cw_data;
                        state_q    <= LOAD;
                    end
                end
                LOAD: begin
                    dec_fram_q <= 1'b1;
                    wcnt_q     <= '0;
                    state_q    <= WAIT;
                end
                WAIT: begin
                    if (bus.dec_qvld) begin
`ifdef DROP_MULTI_ERR_EN
                        if (bus.dec_err_mul) begin
                            state_q <= IDLE;
                        end else begin
                            out_data_q  <= bus.dec_byte;
                            out_err_q   <= {1'b0, bus.dec_err_only};
                            out_valid_q <= 1'b1;
                            state_q     <= OUT;
                        end
`else
                        out_data_q  <= bus.dec_byte;
                        out_err_q   <= {bus.dec_err_mul, bus.dec_err_only};
                        out_valid_q <= 1'b1;
                        state_q     <= OUT;
`endif
                    end else if (enable) begin
                        if (wcnt_q == TW'(TIMEOUT_CYC - 1)) begin
                            timeout_q <= 1'b1;
                            state_q   <= IDLE;
                        end else begin
                            wcnt_q <= wcnt_q + 1'b1;
                        end
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cw_ready  = (state_q == IDLE) && enable;
    assign bus.dec_data  = dec_data_q;
    assign bus.dec_fram  = dec_fram_q;
    assign bus.dec_en    = enable;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_err   = out_err_q;
    assign corr_cnt      = corr_q;
    assign uncorr_cnt    = uncorr_q;
    assign timeout_err   = timeout_q;
    assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_hamming_rx_sequencer.sv
// Bench for hamming_rx_sequencer: decoder stub, output scoreboard, directed vectors.
// Build with +define+DROP_MULTI_ERR_EN to cover the drop configuration.
module tb_hamming_rx_sequencer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       cnt_clr;
    logic [7:0] corr_cnt;
    logic [7:0] uncorr_cnt;
    logic       timeout_err;
    logic       busy;

    hamming_rx_sequencer_if bus();

    hamming_rx_sequencer #(
        .TIMEOUT_CYC(15),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .cnt_clr(cnt_clr),
        .bus(bus),
        .corr_cnt(corr_cnt),
        .uncorr_cnt(uncorr_cnt),
        .timeout_err(timeout_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] cw;
        logic [7:0]  b;
        logic        eo;
        logic        em;
        logic        resp;
    } dec_t;

    typedef struct {
        logic [7:0] d;
        logic [1:0] e;
    } out_t;

    dec_t dq[$];
    out_t oq[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_to = 0;
    int   m_corr = 0;
    int   m_uncorr = 0;
    logic clr_req = 1'b0;
    dec_t stub_r;
    out_t mon_e;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Decoder stub: replies 3 clocks after the frame strobe with the queued result.
    initial begin
        bus.dec_qvld     = 1'b0;
        bus.dec_byte     = '0;
        bus.dec_err_only = 1'b0;
        bus.dec_err_mul  = 1'b0;
        cnt_clr          = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.dec_fram) begin
                if (dq.size() == 0) begin
                    chk("dec_unexp_fram", 1, 0);
                end else begin
                    stub_r = dq.pop_front();
                    chk("dec_data", 32'(bus.dec_data), 32'(stub_r.cw));
                    if (stub_r.resp) begin
                        repeat (2) @(negedge clk);
                        bus.dec_qvld     = 1'b1;
                        bus.dec_byte     = stub_r.b;
                        bus.dec_err_only = stub_r.eo;
                        bus.dec_err_mul  = stub_r.em;
                        cnt_clr          = clr_req;
                        @(negedge clk);
                        bus.dec_qvld     = 1'b0;
                        bus.dec_err_only = 1'b0;
                        bus.dec_err_mul  = 1'b0;
                        cnt_clr          = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: compares each downstream handshake and each timeout pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                if (oq.size() == 0) begin
                    chk("out_unexp", 1, 0);
                end else begin
                    mon_e = oq.pop_front();
                    chk("out_data", 32'(bus.out_data), 32'(mon_e.d));
                    chk("out_err", 32'(bus.out_err), 32'(mon_e.e));
                end
            end
            if (timeout_err) begin
                if (exp_to == 0) chk("timeout_unexp", 1, 0);
                else exp_to--;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) chk("idle_timeout", 1, 0);
    endtask

    task automatic send(logic [11:0] cw, logic [7:0] b, logic eo, logic em,
                        logic resp, logic to, logic wait_done);
        dec_t r;
        out_t o;
        int   n = 0;
        r.cw = cw; r.b = b; r.eo = eo; r.em = em; r.resp = resp;
        dq.push_back(r);
        if (resp) begin
            o.d = b;
            o.e = {em, eo};
`ifdef DROP_MULTI_ERR_EN
            if (!em) oq.push_back(o);
`else
            oq.push_back(o);
`endif
            if (clr_req) begin
                m_corr = 0; m_uncorr = 0;
            end else if (em) begin
                if (m_uncorr < 255) m_uncorr++;
            end else if (eo) begin
                if (m_corr < 255) m_corr++;
            end
        end else if (to) begin
            exp_to++;
        end
        while (!bus.cw_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.cw_ready) chk("cw_ready_timeout", 0, 1);
        bus.cw_valid = 1'b1;
        bus.cw_data  = cw;
        @(posedge clk); #1;
        bus.cw_valid = 1'b0;
        if (wait_done) wait_idle();
    endtask

    task automatic timeout_run(int gap_at, int exp_n);
        int n = 0;
        send(12'hFFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        do begin
            @(posedge clk); #1;
            n++;
            if (n == gap_at) enable = 1'b0;
            if (n == gap_at + 2 && gap_at > 0) chk("dec_en_off", 32'(bus.dec_en), 0);
            if (n == gap_at + 5) enable = 1'b1;
        end while (!timeout_err && n < 40);
        chk("timeout_latency", n, exp_n);
        wait_idle();
        chk("to_busy", 32'(busy), 0);
        chk("to_cw_ready", 32'(bus.cw_ready), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1);
    end

    initial begin
        rst_n         = 1'b0;
        enable        = 1'b0;
        bus.cw_valid  = 1'b0;
        bus.cw_data   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_dec_fram", 32'(bus.dec_fram), 0);
        chk("rst_dec_data", 32'(bus.dec_data), 0);
        chk("rst_cnts", {corr_cnt, uncorr_cnt}, 0);
        chk("rst_timeout", 32'(timeout_err), 0);
        chk("rst_cw_ready", 32'(bus.cw_ready), 0);
        enable = 1'b1;
        #1;
        chk("rst_dec_en", 32'(bus.dec_en), 1);
        @(posedge clk); #1;
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("idle_cw_ready", 32'(bus.cw_ready), 1);

        // clean, single-bit, multi-bit
        send(12'hA5C, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("t1_corr", 32'(corr_cnt), 0);
        chk("t1_uncorr", 32'(uncorr_cnt), 0);
        send(12'h3E1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("t2_corr", 32'(corr_cnt), 1);
        send(12'h5A6, 8'h77, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("t3_uncorr", 32'(uncorr_cnt), 1);
        chk("t3_corr", 32'(corr_cnt), 1);
        chk("t3_oq_empty", oq.size(), 0);

        // decoder never answers; second run freezes the count for 5 clocks
        timeout_run(0, 16);
        timeout_run(4, 21);

        // downstream stall
        bus.out_ready = 1'b0;
        send(12'h1B2, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20 && !bus.out_valid; i++) begin
            @(posedge clk); #1;
        end
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid", 32'(bus.out_valid), 1);
            chk("stall_data", 32'(bus.out_data), 32'hC3);
            chk("stall_cw_ready", 32'(bus.cw_ready), 0);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        wait_idle();

        // saturation
        for (int i = 0; i < 300; i++) begin
            send(12'(i), 8'(i), 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        end
        chk("corr_sat", 32'(corr_cnt), 255);
        chk("corr_model", 32'(corr_cnt), m_corr);

        // clear coinciding with an increment
        clr_req = 1'b1;
        send(12'h0F0, 8'h5E, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        clr_req = 1'b0;
        chk("clr_corr", 32'(corr_cnt), 0);
        chk("clr_uncorr", 32'(uncorr_cnt), 0);

        // async reset while waiting on the decoder
        send(12'h2D4, 8'h81, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("pre_rst_corr", 32'(corr_cnt), m_corr);
        send(12'h777, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("in_wait_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        m_corr   = 0;
        m_uncorr = 0;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_valid", 32'(bus.out_valid), 0);
        chk("mid_rst_cnts", {corr_cnt, uncorr_cnt}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(12'h9C3, 8'h96, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("post_rst_corr", 32'(corr_cnt), 0);

        repeat (3) @(posedge clk); #1;
        chk("end_oq", oq.size(), 0);
        chk("end_dq", dq.size(), 0);
        chk("end_to", exp_to, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
